// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a single borrow flop. Start/done handshake; results are
// held until the next operation completes.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow
);
  // One extra bit so the terminal count is representable for any N.
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sh_a, sh_b, res;
  logic [CW-1:0] cnt;
  logic          bin, a_msb, b_msb;
  logic          accept, last, d, bout;

  // Full-subtractor bit slice on the current LSBs.
  assign d    = sh_a[0] ^ sh_b[0] ^ bin;
  assign bout = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & bin);
  assign last = (cnt == LAST);

  // State register; reset drops busy/done immediately via the decode below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; start only matters when not shifting.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = start;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      res      <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= b;
      res   <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
      a_msb <= a[N-1];
      b_msb <= b[N-1];
    end else if (state == SHIFT) begin
      sh_a <= {1'b0, sh_a[N-1:1]};
      sh_b <= {1'b0, sh_b[N-1:1]};
      res  <= {d, res[N-1:1]};
      bin  <= bout;
      cnt  <= cnt + CW'(1);
      // Publish the whole result at once so it is never partially visible;
      // d on the last bit is the result MSB.
      if (last) begin
        diff     <= {d, res[N-1:1]};
        borrow   <= bout;
        overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at N=8 and N=16.
module tb_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done, borrow, overflow;
  logic [7:0]  diff;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, borrow16, overflow16;
  logic [15:0] diff16;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  serial_subtractor #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .overflow(overflow16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation: checks latency, diff stability while busy, results,
  // and that a start poked during SHIFT is not queued.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ed, input logic eb, input logic eo);
    logic [7:0] prev;
    int nb;
    prev  = diff;
    a     = va;
    b     = vb;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    nb    = 0;
    while (busy && nb < 40) begin
      nb++;
      chk({tag, "_stable"}, {24'h0, diff}, {24'h0, prev});
      start = (nb == 3);
      step();
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_done"}, {31'h0, done}, 1);
    chk({tag, "_diff"}, {24'h0, diff}, {24'h0, ed});
    chk({tag, "_borrow"}, {31'h0, borrow}, {31'h0, eb});
    chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, eo});
    step();
    chk({tag, "_idle_done"}, {31'h0, done}, 0);
    chk({tag, "_idle_busy"}, {31'h0, busy}, 0);
    chk({tag, "_hold"}, {24'h0, diff}, {24'h0, ed});
  endtask

  initial begin
    logic [7:0] ca, cb, cd;
    logic [7:0] hist_a [0:40];
    logic [7:0] hist_b [0:40];
    int nb;

    #12;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_diff", {24'h0, diff}, 0);
    chk("rst_borrow", {31'h0, borrow}, 0);
    chk("rst_ovf", {31'h0, overflow}, 0);
    chk("rst_diff16", {16'h0, diff16}, 0);
    rst_n = 1'b1;
    step();

    run_op("t100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    run_op("t5_10", 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
    run_op("t0_0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // start held high, operands changing every cycle: accepts at cycles
    // 0, 9, 18, 27; results visible after cycles 8, 17, 26, 35.
    start = 1'b1;
    for (int c = 0; c < 36; c++) begin
      a = 8'(c * 37 + 11);
      b = 8'(c * 91 + 200);
      hist_a[c] = a;
      hist_b[c] = b;
      step();
      if (c % 9 == 8) begin
        ca = hist_a[c-8];
        cb = hist_b[c-8];
        cd = ca - cb;
        chk("b2b_done", {31'h0, done}, 1);
        chk("b2b_diff", {24'h0, diff}, {24'h0, cd});
        chk("b2b_borrow", {31'h0, borrow}, {31'h0, (ca < cb)});
        chk("b2b_ovf", {31'h0, overflow}, {31'h0, (ca[7] != cb[7]) && (cd[7] != ca[7])});
      end else begin
        chk("b2b_busy", {31'h0, busy}, 1);
        chk("b2b_nodone", {31'h0, done}, 0);
      end
    end
    start = 1'b0;
    step();
    chk("b2b_end_idle", {31'h0, busy | done}, 0);

    // Reset in the 4th SHIFT cycle, after a nonzero result is held.
    run_op("pre_rst", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    a = 8'h12; b = 8'h34; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mid_busy", {31'h0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 0);
    chk("arst_done", {31'h0, done}, 0);
    chk("arst_diff", {24'h0, diff}, 0);
    chk("arst_borrow", {31'h0, borrow}, 0);
    chk("arst_ovf", {31'h0, overflow}, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      chk("arst_nodone", {31'h0, done}, 0);
    end
    run_op("tff_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

    // N=16 instance.
    a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    step();
    start16 = 1'b0;
    a16 = '0; b16 = '1;
    nb = 0;
    while (busy16 && nb < 40) begin
      nb++;
      step();
    end
    chk("n16_busy_cycles", nb, 16);
    chk("n16_done", {31'h0, done16}, 1);
    chk("n16_diff", {16'h0, diff16}, 32'h0000CF13);
    chk("n16_borrow", {31'h0, borrow16}, 1);
    chk("n16_ovf", {31'h0, overflow16}, 0);
    step();
    chk("n16_pulse", {31'h0, done16}, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
